// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART receiver: default frame markers,
// FSM state encodings and the clock-to-baud divisor helper.
package uart_pkg;

  localparam int DIV_W         = 32;
  localparam int PAYLOAD_BYTES = 7;
  localparam int FRAME_BYTES   = 10;

  localparam logic [7:0] HEAD0_DEF = 8'h55;
  localparam logic [7:0] HEAD1_DEF = 8'hA5;
  localparam logic [7:0] TAIL_DEF  = 8'hF0;

  // Byte receiver states: waiting for a start edge, confirming the start bit
  // at its mid-point, collecting data bits, checking the stop bit.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } byte_state_t;

  // Frame states: hunting for HEAD0, HEAD0 seen, collecting payload, tail due.
  typedef enum logic [1:0] {
    FR_IDLE      = 2'd0,
    FR_GOT_H0    = 2'd1,
    FR_BODY      = 2'd2,
    FR_WAIT_TAIL = 2'd3
  } frame_state_t;

  // Clock cycles per bit, rounded down. Codes 5-7 fall back to 115200.
  function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_hz,
                                                input logic [2:0]  baud_set);
    int unsigned baud;
    case (baud_set)
      3'd0:    baud = 9600;
      3'd1:    baud = 19200;
      3'd2:    baud = 38400;
      3'd3:    baud = 57600;
      default: baud = 115200;
    endcase
    return DIV_W'(clk_hz / baud);
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: synchronizes the serial line, detects the start edge,
// samples each bit at its mid-point and flags a good or bad stop bit.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_async,
  input  logic [2:0]       baud_set,
  output logic [7:0]       rx_byte,
  output logic             byte_valid,
  output logic             byte_err,
  output logic [DIV_W-1:0] bit_div,
  output byte_state_t      state_dbg
);

  localparam logic [DIV_W-1:0] DIV_9600   = baud_div(CLK_HZ, 3'd0);
  localparam logic [DIV_W-1:0] DIV_19200  = baud_div(CLK_HZ, 3'd1);
  localparam logic [DIV_W-1:0] DIV_38400  = baud_div(CLK_HZ, 3'd2);
  localparam logic [DIV_W-1:0] DIV_57600  = baud_div(CLK_HZ, 3'd3);
  localparam logic [DIV_W-1:0] DIV_115200 = baud_div(CLK_HZ, 3'd4);

  byte_state_t      state, state_nxt;
  logic [1:0]       sync_q;
  logic             rx_prev;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] div_q, div_nxt;
  logic [DIV_W-1:0] sel_div;
  logic [DIV_W-1:0] half_m1;
  logic [DIV_W-1:0] full_m1;
  logic [2:0]       bit_idx, bit_nxt;
  logic [7:0]       shreg, sh_nxt;
  logic             valid_nxt, err_nxt;
  logic             rx_s;
  logic             falling;

  assign rx_s      = sync_q[1];
  assign falling   = rx_prev & ~rx_s;
  assign half_m1   = (div_q >> 1) - DIV_W'(1);
  assign full_m1   = div_q - DIV_W'(1);
  assign rx_byte   = shreg;
  assign bit_div   = div_q;
  assign state_dbg = state;

  // Divisor for the currently requested rate; only sampled at the start edge.
  always_comb begin
    sel_div = DIV_115200;
    case (baud_set)
      3'd0:    sel_div = DIV_9600;
      3'd1:    sel_div = DIV_19200;
      3'd2:    sel_div = DIV_38400;
      3'd3:    sel_div = DIV_57600;
      default: sel_div = DIV_115200;
    endcase
  end

  // Next-state, bit timing and byte assembly.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + DIV_W'(1);
    div_nxt   = div_q;
    bit_nxt   = bit_idx;
    sh_nxt    = shreg;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_nxt = '0;
        if (falling) begin
          state_nxt = RX_START;
          div_nxt   = sel_div;
        end
      end
      RX_START: begin
        if (cnt == half_m1) begin
          cnt_nxt = '0;
          bit_nxt = 3'd0;
          // A line that is high again at mid-start was only a glitch.
          state_nxt = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == full_m1) begin
          cnt_nxt = '0;
          sh_nxt  = {rx_s, shreg[7:1]};
          if (bit_idx == 3'd7) state_nxt = RX_STOP;
          else                 bit_nxt   = bit_idx + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt == full_m1) begin
          cnt_nxt   = '0;
          state_nxt = RX_IDLE;
          valid_nxt = rx_s;
          err_nxt   = ~rx_s;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  // Synchronizer, edge history and receiver state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= 2'b11;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      div_q      <= '0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx_async};
      rx_prev    <= rx_s;
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      div_q      <= div_nxt;
      bit_idx    <= bit_nxt;
      shreg      <= sh_nxt;
      byte_valid <= valid_nxt;
      byte_err   <= err_nxt;
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// Framed UART receiver: HEAD0 HEAD1 + 7 payload bytes + TAIL. A complete
// frame updates data and pulses Rx_Done; a broken or stalled frame pulses
// frame_err and leaves data untouched.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter logic [7:0]  HEAD0    = HEAD0_DEF,
  parameter logic [7:0]  HEAD1    = HEAD1_DEF,
  parameter logic [7:0]  TAIL     = TAIL_DEF,
  parameter int unsigned GAP_BITS = 20
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        uart_rx,
  input  logic [2:0]  Baud_Set,
  output logic [79:0] data,
  output logic        Rx_Done,
  output logic        frame_err,
  output logic        uart_state
);

  logic [7:0]       rx_byte;
  logic             byte_valid;
  logic             byte_err;
  logic [DIV_W-1:0] bit_div;
  byte_state_t      byte_state;

  frame_state_t     frame_state, frame_nxt;
  logic [55:0]      pay_buf, pay_nxt;
  logic [2:0]       pay_cnt, pay_cnt_nxt;
  logic [DIV_W-1:0] gap_cnt;
  logic [DIV_W-1:0] gap_limit;
  logic             done_nxt, ferr_nxt, load_nxt;
  logic             gap_expired;

  uart_byte_rx #(
    .CLK_HZ (CLK_HZ)
  ) u_byte_rx (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .rx_async   (uart_rx),
    .baud_set   (Baud_Set),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .byte_err   (byte_err),
    .bit_div    (bit_div),
    .state_dbg  (byte_state)
  );

  // Gap budget follows the rate of the most recent byte.
  assign gap_limit   = DIV_W'(GAP_BITS) * bit_div;
  assign gap_expired = (gap_cnt >= gap_limit);
  assign uart_state  = (byte_state != RX_IDLE) || (frame_state != FR_IDLE);

  // Frame FSM next-state; byte errors and gap timeouts abort any open frame.
  always_comb begin
    frame_nxt   = frame_state;
    pay_nxt     = pay_buf;
    pay_cnt_nxt = pay_cnt;
    done_nxt    = 1'b0;
    ferr_nxt    = 1'b0;
    load_nxt    = 1'b0;
    if (byte_err) begin
      if (frame_state != FR_IDLE) begin
        ferr_nxt  = 1'b1;
        frame_nxt = FR_IDLE;
      end
    end else if (byte_valid) begin
      case (frame_state)
        FR_IDLE: begin
          if (rx_byte == HEAD0) frame_nxt = FR_GOT_H0;
        end
        FR_GOT_H0: begin
          if (rx_byte == HEAD1) begin
            frame_nxt   = FR_BODY;
            pay_cnt_nxt = 3'd0;
          end else if (rx_byte != HEAD0) begin
            frame_nxt = FR_IDLE;
            ferr_nxt  = 1'b1;
          end
        end
        FR_BODY: begin
          pay_nxt = {pay_buf[47:0], rx_byte};
          if (pay_cnt == 3'(PAYLOAD_BYTES - 1)) frame_nxt   = FR_WAIT_TAIL;
          else                                  pay_cnt_nxt = pay_cnt + 3'd1;
        end
        FR_WAIT_TAIL: begin
          frame_nxt = FR_IDLE;
          if (rx_byte == TAIL) begin
            done_nxt = 1'b1;
            load_nxt = 1'b1;
          end else begin
            ferr_nxt = 1'b1;
          end
        end
        default: frame_nxt = FR_IDLE;
      endcase
    end else if ((frame_state != FR_IDLE) && gap_expired) begin
      ferr_nxt  = 1'b1;
      frame_nxt = FR_IDLE;
    end
  end

  // Frame state, payload buffer, gap timer and output registers.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      frame_state <= FR_IDLE;
      pay_buf     <= '0;
      pay_cnt     <= 3'd0;
      gap_cnt     <= '0;
      data        <= '0;
      Rx_Done     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_state <= frame_nxt;
      pay_buf     <= pay_nxt;
      pay_cnt     <= pay_cnt_nxt;
      if ((frame_state == FR_IDLE) || (byte_state != RX_IDLE)) gap_cnt <= '0;
      else                                                    gap_cnt <= gap_cnt + DIV_W'(1);
      if (load_nxt) data <= {HEAD0, HEAD1, pay_buf, TAIL};
      Rx_Done     <= done_nxt;
      frame_err   <= ferr_nxt;
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx. The DUT is built with CLK_HZ = 3 MHz so a bit is
// 26 cycles at 115200 (3e6/115200 = 26.04) and 312 cycles at 9600
// (3e6/9600 = 312.5), keeping every frame short. Each DUT pulse is checked
// against an expected queue entry {is_err, data_expected}.
module tb_uart_frame_rx;
  import uart_pkg::*;

  localparam int BIT4 = 26;
  localparam int BIT0 = 312;

  localparam logic [79:0] FRAME_A  = 80'h55_A5_00_00_11_00_00_00_00_F0;
  localparam logic [79:0] FRAME_B  = 80'h55_A5_68_04_35_05_06_07_08_F0;
  localparam logic [79:0] FRAME_BT = 80'h55_A5_68_04_35_05_06_07_08_F1;
  localparam logic [79:0] FRAME_D  = 80'h55_A5_11_22_33_44_55_66_77_F0;

  logic        Clk      = 1'b0;
  logic        Rst_n    = 1'b0;
  logic        uart_rx  = 1'b1;
  logic [2:0]  Baud_Set = 3'd4;
  logic [79:0] data;
  logic        Rx_Done;
  logic        frame_err;
  logic        uart_state;

  int checks = 0;
  int fails  = 0;
  logic [80:0] exp_q[$];

  uart_frame_rx #(
    .CLK_HZ (3_000_000)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .uart_rx    (uart_rx),
    .Baud_Set   (Baud_Set),
    .data       (data),
    .Rx_Done    (Rx_Done),
    .frame_err  (frame_err),
    .uart_state (uart_state)
  );

  // Clock: 20 ns period.
  always #10 Clk = ~Clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_done(input logic [79:0] d);
    exp_q.push_back({1'b0, d});
  endtask

  task automatic push_err(input logic [79:0] d);
    exp_q.push_back({1'b1, d});
  endtask

  task automatic expect_drained(input string name);
    check(name, 80'(exp_q.size()), 80'd0);
  endtask

  // Driver: one 8N1 byte, starting and ending on a falling clock edge.
  task automatic send_byte(input logic [7:0] b, input int bit_cyc, input logic [2:0] bs,
                           input bit stop_low, input bit scramble);
    Baud_Set = bs;
    uart_rx  = 1'b0;
    repeat (bit_cyc) @(negedge Clk);
    if (scramble) Baud_Set = (bs == 3'd4) ? 3'd0 : 3'd4;
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (bit_cyc) @(negedge Clk);
    end
    Baud_Set = bs;
    uart_rx  = ~stop_low;
    repeat (bit_cyc) @(negedge Clk);
    uart_rx  = 1'b1;
  endtask

  // Driver: first nbytes of a frame, back to back, optionally one bad stop bit.
  task automatic uart_data_tx(input logic [79:0] f, input int nbytes, input int bit_cyc,
                              input logic [2:0] bs, input int bad_idx, input bit scramble);
    logic [79:0] t;
    t = f;
    for (int k = 0; k < nbytes; k++) begin
      send_byte(t[79:72], bit_cyc, bs, (k == bad_idx), scramble);
      t = t << 8;
    end
  endtask

  // Monitor: every Rx_Done / frame_err pulse pops and checks one expectation.
  always @(negedge Clk) begin
    logic [80:0] e;
    if (Rst_n && (Rx_Done || frame_err)) begin
      check("pulse_exclusive", {79'd0, Rx_Done & frame_err}, 80'd0);
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pulse: got Rx_Done=%b frame_err=%b data=%h expected no pulse",
                 Rx_Done, frame_err, data);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {79'd0, frame_err}, {79'd0, e[80]});
        check("pulse_data", data, e[79:0]);
      end
    end
  end

  // Stimulus sequence.
  initial begin
    repeat (3) @(negedge Clk);
    check("reset_data",       data,               80'd0);
    check("reset_rx_done",    {79'd0, Rx_Done},    80'd0);
    check("reset_frame_err",  {79'd0, frame_err},  80'd0);
    check("reset_uart_state", {79'd0, uart_state}, 80'd0);
    Rst_n = 1'b1;
    repeat (5) @(negedge Clk);

    // Divisor table at the default 50 MHz clock.
    check("div_9600",   80'(baud_div(50_000_000, 3'd0)), 80'd5208);
    check("div_19200",  80'(baud_div(50_000_000, 3'd1)), 80'd2604);
    check("div_38400",  80'(baud_div(50_000_000, 3'd2)), 80'd1302);
    check("div_57600",  80'(baud_div(50_000_000, 3'd3)), 80'd868);
    check("div_115200", 80'(baud_div(50_000_000, 3'd4)), 80'd434);
    check("div_code7",  80'(baud_div(50_000_000, 3'd7)), 80'd434);

    // Single good frame.
    push_done(FRAME_A);
    uart_data_tx(FRAME_A, 10, BIT4, 3'd4, -1, 1'b0);
    repeat (4) @(negedge Clk);
    expect_drained("single_frame");

    // Two frames with no idle between them.
    push_done(FRAME_A);
    push_done(FRAME_B);
    uart_data_tx(FRAME_A, 10, BIT4, 3'd4, -1, 1'b0);
    uart_data_tx(FRAME_B, 10, BIT4, 3'd4, -1, 1'b0);
    repeat (4) @(negedge Clk);
    expect_drained("back_to_back");

    // Wrong tail: error, data keeps FRAME_B.
    push_err(FRAME_B);
    uart_data_tx(FRAME_BT, 10, BIT4, 3'd4, -1, 1'b0);
    repeat (4) @(negedge Clk);
    expect_drained("bad_tail");
    check("bad_tail_data_kept", data, FRAME_B);

    // Stop bit low in the fifth byte, then a good frame.
    push_err(FRAME_B);
    uart_data_tx(FRAME_A, 10, BIT4, 3'd4, 4, 1'b0);
    repeat (3 * BIT4) @(negedge Clk);
    expect_drained("bad_stop");
    push_done(FRAME_D);
    uart_data_tx(FRAME_D, 10, BIT4, 3'd4, -1, 1'b0);
    repeat (4) @(negedge Clk);
    expect_drained("after_bad_stop");

    // 200 ns low glitch while idle.
    uart_rx = 1'b0;
    repeat (10) @(negedge Clk);
    uart_rx = 1'b1;
    repeat (3 * BIT4) @(negedge Clk);
    check("glitch_idle_state", {79'd0, uart_state}, 80'd0);
    expect_drained("glitch");

    // Five bytes then 25 idle bit periods: gap timeout.
    push_err(FRAME_D);
    uart_data_tx(FRAME_D, 5, BIT4, 3'd4, -1, 1'b0);
    repeat (10 * BIT4) @(negedge Clk);
    check("partial_in_progress", {79'd0, uart_state}, 80'd1);
    repeat (15 * BIT4) @(negedge Clk);
    check("partial_timed_out", {79'd0, uart_state}, 80'd0);
    expect_drained("gap_timeout");

    // One-cycle reset in the middle of a byte of an open frame.
    uart_data_tx(FRAME_B, 4, BIT4, 3'd4, -1, 1'b0);
    fork
      send_byte(8'h00, BIT4, 3'd4, 1'b0, 1'b0);
      begin
        repeat (4 * BIT4) @(negedge Clk);
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        check("midreset_data",       data,               80'd0);
        check("midreset_rx_done",    {79'd0, Rx_Done},    80'd0);
        check("midreset_frame_err",  {79'd0, frame_err},  80'd0);
        check("midreset_uart_state", {79'd0, uart_state}, 80'd0);
      end
    join
    repeat (15 * BIT4) @(negedge Clk);
    expect_drained("midreset_no_pulse");

    // Full frame at 9600 with Baud_Set disturbed during each byte.
    push_done(FRAME_B);
    uart_data_tx(FRAME_B, 10, BIT0, 3'd0, -1, 1'b1);
    repeat (4) @(negedge Clk);
    expect_drained("baud_9600");
    check("final_data", data, FRAME_B);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Watchdog.
  initial begin
    #10ms;
    $display("FAIL watchdog: simulation did not complete, expected finish before 10 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
